// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: datapath sizes,
// ALU opcodes, the instruction word layout and the control FSM states.
package alu_issue_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int NREGS   = 8;
  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 16;
  localparam int IMM_W   = 6;

  // Opcodes are passed straight through to the ALU; only ADD is special here
  // because it is the one operation whose carry becomes architectural.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  // Instruction word, MSB first:
  // [15:13] opcode, [12:10] rd, [9:7] ra, [6] imm_sel, [5:3] reserved, [2:0] rb.
  // With imm_sel set, [5:0] (reserved + rb) form a zero-extended immediate.
  typedef struct packed {
    opcode_e           opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] ra;
    logic              imm_sel;
    logic [2:0]        rsvd;
    logic [ADDR_W-1:0] rb;
  } instr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

  // Zero-extended 6-bit immediate taken from the low bits of the instruction.
  function automatic logic [DATA_W-1:0] imm_operand(input instr_t instr);
    return {{(DATA_W-IMM_W){1'b0}}, instr.rsvd, instr.rb};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the controller's instruction, ALU, writeback and debug signals.
// master = the issue controller, slave = its environment (fetch path + ALU).
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic                instr_valid;
  logic [INSTR_W-1:0]  instr_data;
  logic                instr_ready;

  opcode_e             alu_opcode;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_zero;
  logic                alu_carry;

  logic                wb_valid;
  logic [ADDR_W-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;

  logic                flag_z;
  logic                flag_c;

  logic [ADDR_W-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    input  instr_valid, instr_data, alu_out, alu_zero, alu_carry, dbg_addr,
    output instr_ready, alu_opcode, alu_a, alu_b, wb_valid, wb_addr, wb_data,
           flag_z, flag_c, dbg_data
  );

  modport slave (
    output instr_valid, instr_data, alu_out, alu_zero, alu_carry, dbg_addr,
    input  instr_ready, alu_opcode, alu_a, alu_b, wb_valid, wb_addr, wb_data,
           flag_z, flag_c, dbg_data
  );

endinterface

// File: rtl/alu_issue_ctrl_reg_file_8x8.sv
// 8 x 8-bit register file: one synchronous write port, two combinational
// operand read ports and a combinational debug read port. R0 reads as zero
// and ignores writes.
module reg_file_8x8
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register storage: cleared on reset, written on we_i except for R0.
  // NOTE: this array is small flops, not a RAM macro, so clearing every entry
  // on reset is cheap and gives software a known register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      // NOTE: clocked state always uses <= so every flop samples pre-edge values.
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // R0 is forced to zero on read so it never depends on storage contents.
  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : regs_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU. Accepts one instruction
// every three cycles (IDLE -> EXEC -> WB), registers opcode and operands
// toward the ALU, captures result and flags, and writes the result back.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
);

  state_e            state_q, state_d;
  instr_t            instr;
  logic              accept;
  logic              ready;
  logic              wb_en;

  opcode_e           opcode_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] result_q;
  logic              flag_z_q, flag_c_q;

  logic [DATA_W-1:0] rdata_a, rdata_b;

  assign instr  = instr_t'(bus.instr_data);
  assign accept = bus.instr_valid && ready;

  reg_file_8x8 u_reg_file (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wb_en),
    .waddr_i    (rd_q),
    .wdata_i    (result_q),
    .raddr_a_i  (instr.ra),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (instr.rb),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (bus.dbg_addr),
    .dbg_data_o (bus.dbg_data)
  );

  // FSM state register; reset abandons any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and state-decoded strobes.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    wb_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        wb_en   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ALU-side registers: opcode, destination and operands latched on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q <= OP_ADD;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (accept) begin
      opcode_q <= instr.opcode;
      rd_q     <= instr.rd;
      a_q      <= rdata_a;
      b_q      <= instr.imm_sel ? imm_operand(instr) : rdata_b;
    end
  end

  // Result and flags captured at the end of EXEC; carry is architectural
  // only for ADD, every other opcode leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      result_q <= bus.alu_out;
      flag_z_q <= bus.alu_zero;
      if (opcode_q == OP_ADD) flag_c_q <= bus.alu_carry;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.wb_valid    = wb_en;
  assign bus.wb_addr     = rd_q;
  assign bus.wb_data     = result_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural ALU: carry is bit 8 of the widened result; SUB yields borrow,
  // shifts yield the bit shifted out (the controller must ignore those).
  logic [8:0] wide;
  always_comb begin
    wide = '0;
    case (bus.alu_opcode)
      OP_ADD: wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_SUB: wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_AND: wide = {1'b0, bus.alu_a & bus.alu_b};
      OP_OR:  wide = {1'b0, bus.alu_a | bus.alu_b};
      OP_XOR: wide = {1'b0, bus.alu_a ^ bus.alu_b};
      OP_NOT: wide = {1'b0, ~bus.alu_a};
      OP_SHL: wide = {bus.alu_a, 1'b0};
      OP_SHR: wide = {bus.alu_a[0], 1'b0, bus.alu_a[7:1]};
      default: wide = '0;
    endcase
    bus.alu_out   = wide[7:0];
    bus.alu_carry = wide[8];
    bus.alu_zero  = (wide[7:0] == 8'h00);
  end

  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, 1'b0, 3'b000, rb};
  endfunction

  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] ra, input logic [5:0] imm);
    return {op, rd, ra, 1'b1, imm};
  endfunction

  // Observations captured by exec_instr during EXEC and WB.
  logic       ex_ready, ex_wbv;
  logic [2:0] ex_op;
  logic [7:0] ex_a, ex_b;
  logic       wb_v;
  logic [2:0] wb_a;
  logic [7:0] wb_d;
  logic       fz, fc;
  logic [7:0] dv;

  task automatic peek(input logic [2:0] addr, output logic [7:0] val);
    bus.dbg_addr = addr;
    #1;
    val = bus.dbg_data;
  endtask

  // Issue one instruction and step through EXEC and WB, ending in IDLE.
  task automatic exec_instr(input logic [15:0] ins);
    int n;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = ins;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (bus.instr_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: instr_ready=%b want 1", bus.instr_ready);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    ex_ready = bus.instr_ready;
    ex_wbv   = bus.wb_valid;
    ex_op    = bus.alu_opcode;
    ex_a     = bus.alu_a;
    ex_b     = bus.alu_b;
    @(negedge clk);
    wb_v = bus.wb_valid;
    wb_a = bus.wb_addr;
    wb_d = bus.wb_data;
    fz   = bus.flag_z;
    fc   = bus.flag_c;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    bus.dbg_addr    = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus.instr_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b exp 0", bus.wb_valid); end
    checks++; if (bus.alu_opcode !== 3'd0) begin errors++; $display("FAIL reset_opcode: got %h exp 0", bus.alu_opcode); end
    checks++; if ({bus.alu_a, bus.alu_b} !== 16'h0000) begin errors++; $display("FAIL reset_operands: got %h exp 0000", {bus.alu_a, bus.alu_b}); end
    checks++; if ({bus.flag_z, bus.flag_c} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {bus.flag_z, bus.flag_c}); end
    checks++; if ({bus.wb_addr, bus.wb_data} !== 11'h000) begin errors++; $display("FAIL reset_wb_bus: got %h exp 000", {bus.wb_addr, bus.wb_data}); end
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), dv);
      checks++; if (dv !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %h exp 00", i, dv); end
    end
  endtask

  task automatic test_imm_load();
    exec_instr(enc_i(3'd0, 3'd1, 3'd0, 6'h3F));
    checks++; if ({ex_ready, ex_wbv} !== 2'b00) begin errors++; $display("FAIL imm_exec_strobes: got %b exp 00", {ex_ready, ex_wbv}); end
    checks++; if ({ex_a, ex_b} !== 16'h003F) begin errors++; $display("FAIL imm_operands: got %h exp 003f", {ex_a, ex_b}); end
    checks++; if ({wb_v, wb_a} !== 4'b1001) begin errors++; $display("FAIL imm_wb_addr: got %b exp 1001", {wb_v, wb_a}); end
    checks++; if (wb_d !== 8'h3F) begin errors++; $display("FAIL imm_wb_data: got %h exp 3f", wb_d); end
    checks++; if ({fz, fc} !== 2'b00) begin errors++; $display("FAIL imm_flags: got %b exp 00", {fz, fc}); end
    peek(3'd1, dv);
    checks++; if (dv !== 8'h3F) begin errors++; $display("FAIL imm_dbg_r1: got %h exp 3f", dv); end
  endtask

  task automatic test_carry_zero();
    exec_instr(enc_i(3'd0, 3'd1, 3'd1, 6'h3F));
    exec_instr(enc_i(3'd0, 3'd1, 3'd1, 6'h3F));
    exec_instr(enc_i(3'd0, 3'd1, 3'd1, 6'h3F));
    exec_instr(enc_i(3'd0, 3'd1, 3'd1, 6'h03));
    checks++; if (wb_d !== 8'hFF) begin errors++; $display("FAIL chain_r1: got %h exp ff", wb_d); end
    exec_instr(enc_r(3'd0, 3'd2, 3'd1, 3'd1));
    checks++; if (wb_d !== 8'hFE) begin errors++; $display("FAIL add_carry_data: got %h exp fe", wb_d); end
    checks++; if ({fz, fc} !== 2'b01) begin errors++; $display("FAIL add_carry_flags: got %b exp 01", {fz, fc}); end
    exec_instr(enc_r(3'd4, 3'd3, 3'd1, 3'd1));
    checks++; if (wb_d !== 8'h00) begin errors++; $display("FAIL xor_zero_data: got %h exp 00", wb_d); end
    checks++; if ({fz, fc} !== 2'b11) begin errors++; $display("FAIL xor_flags_c_held: got %b exp 11", {fz, fc}); end
    peek(3'd2, dv);
    checks++; if (dv !== 8'hFE) begin errors++; $display("FAIL dbg_r2: got %h exp fe", dv); end
  endtask

  task automatic test_r0_write();
    exec_instr(enc_r(3'd3, 3'd0, 3'd1, 3'd1));
    checks++; if ({wb_v, wb_a} !== 4'b1000) begin errors++; $display("FAIL r0_wb_strobe: got %b exp 1000", {wb_v, wb_a}); end
    checks++; if (wb_d !== 8'hFF) begin errors++; $display("FAIL r0_wb_data: got %h exp ff", wb_d); end
    peek(3'd0, dv);
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL r0_dbg: got %h exp 00", dv); end
  endtask

  task automatic test_unary();
    exec_instr(enc_i(3'd0, 3'd6, 3'd0, 6'h20));
    exec_instr(enc_r(3'd0, 3'd6, 3'd6, 3'd6));
    exec_instr(enc_i(3'd4, 3'd1, 3'd1, 6'h3E));
    exec_instr(enc_r(3'd4, 3'd1, 3'd1, 3'd6));
    checks++; if ({wb_d, fc} !== 9'h102) begin errors++; $display("FAIL setup_r1_81: got %h exp 102", {wb_d, fc}); end
    exec_instr(enc_r(3'd6, 3'd2, 3'd1, 3'd0));
    checks++; if ({ex_op, ex_a, ex_b} !== {3'd6, 8'h81, 8'h00}) begin errors++; $display("FAIL shl_alu_ports: got %h", {ex_op, ex_a, ex_b}); end
    checks++; if ({wb_d, fc} !== 9'h004) begin errors++; $display("FAIL shl_result: got %h exp 004", {wb_d, fc}); end
    exec_instr(enc_i(3'd7, 3'd3, 3'd1, 6'h05));
    checks++; if (ex_b !== 8'h05) begin errors++; $display("FAIL shr_imm_b: got %h exp 05", ex_b); end
    checks++; if ({wb_d, fc} !== 9'h080) begin errors++; $display("FAIL shr_result: got %h exp 080", {wb_d, fc}); end
    exec_instr(enc_r(3'd5, 3'd4, 3'd1, 3'd2));
    checks++; if (ex_b !== 8'h02) begin errors++; $display("FAIL not_reg_b: got %h exp 02", ex_b); end
    checks++; if ({wb_d, fc} !== 9'h0FC) begin errors++; $display("FAIL not_result: got %h exp 0fc", {wb_d, fc}); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prog [3];
    logic [18:0] exp_ex [3];
    logic [7:0]  exp_wb [3];
    logic [2:0]  exp_rd [3];
    prog[0] = enc_r(3'd0, 3'd5, 3'd1, 3'd2); exp_ex[0] = {3'd0, 8'h81, 8'h02}; exp_wb[0] = 8'h83; exp_rd[0] = 3'd5;
    prog[1] = enc_i(3'd1, 3'd7, 3'd5, 6'h03); exp_ex[1] = {3'd1, 8'h83, 8'h03}; exp_wb[1] = 8'h80; exp_rd[1] = 3'd7;
    prog[2] = enc_r(3'd2, 3'd5, 3'd7, 3'd4); exp_ex[2] = {3'd2, 8'h80, 8'h7E}; exp_wb[2] = 8'h00; exp_rd[2] = 3'd5;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr_data  = (c % 3 == 0) ? prog[c / 3] : 16'hFFFF;
      checks++; if (bus.instr_ready !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ready_c%0d: got %b exp %b", c, bus.instr_ready, (c % 3 == 0)); end
      if (c % 3 == 1) begin
        checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== exp_ex[c / 3]) begin errors++; $display("FAIL b2b_alu_ports_%0d: got %h exp %h", c / 3, {bus.alu_opcode, bus.alu_a, bus.alu_b}, exp_ex[c / 3]); end
      end
      if (c % 3 == 2) begin
        checks++; if ({bus.wb_valid, bus.wb_addr, bus.wb_data} !== {1'b1, exp_rd[c / 3], exp_wb[c / 3]}) begin errors++; $display("FAIL b2b_wb_%0d: got %h exp %h", c / 3, {bus.wb_valid, bus.wb_addr, bus.wb_data}, {1'b1, exp_rd[c / 3], exp_wb[c / 3]}); end
      end
      if (c == 8) begin
        checks++; if (bus.flag_z !== 1'b1) begin errors++; $display("FAIL b2b_flag_z: got %b exp 1", bus.flag_z); end
        bus.instr_valid = 1'b0;
      end
    end
    @(negedge clk);
    peek(3'd7, dv);
    checks++; if (dv !== 8'h80) begin errors++; $display("FAIL b2b_dbg_r7: got %h exp 80", dv); end
    peek(3'd5, dv);
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL b2b_dbg_r5: got %h exp 00", dv); end
  endtask

  task automatic test_reset_mid_exec();
    logic seen_wb;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_data  = enc_r(3'd0, 3'd4, 3'd1, 3'd1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    checks++; if (bus.alu_a !== 8'h81) begin errors++; $display("FAIL rstmid_exec_a: got %h exp 81", bus.alu_a); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.wb_valid, bus.instr_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_strobes: got %b exp 01", {bus.wb_valid, bus.instr_ready}); end
    checks++; if ({bus.alu_opcode, bus.alu_a, bus.alu_b} !== 19'h0) begin errors++; $display("FAIL rstmid_alu_ports: got %h exp 0", {bus.alu_opcode, bus.alu_a, bus.alu_b}); end
    checks++; if ({bus.flag_z, bus.flag_c, bus.wb_addr, bus.wb_data} !== 13'h0) begin errors++; $display("FAIL rstmid_flags_wb: got %h exp 0", {bus.flag_z, bus.flag_c, bus.wb_addr, bus.wb_data}); end
    rst = 1'b0;
    seen_wb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.wb_valid !== 1'b0) seen_wb = 1'b1;
    end
    checks++; if (seen_wb !== 1'b0) begin errors++; $display("FAIL rstmid_no_wb: got %b exp 0", seen_wb); end
    peek(3'd4, dv);
    checks++; if (dv !== 8'h00) begin errors++; $display("FAIL rstmid_r4: got %h exp 00", dv); end
  endtask

  initial begin
    test_reset();
    test_imm_load();
    test_carry_zero();
    test_r0_write();
    test_unary();
    test_back_to_back();
    test_reset_mid_exec();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Execution-control block that drives the core's 8-bit combinational ALU: accepts 16-bit register-to-register instructions over a valid/ready handshake, reads operands from an internal register file, presents them to the ALU, captures result and flags, and writes the result back. It is the initiator side of the ALU interface (opcode/a/b out; out/zero/carry in) and sits between the instruction fetch path and the ALU.

## Interface
- `DATA_W`, 8, datapath width; must match the ALU.
- `NREGS`, 8, register count; address width 3.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `instr_valid`  in  1  instruction available.
- `instr_data`  in  16  [15:13] opcode, [12:10] rd, [9:7] ra, [6] imm_sel, [5:3] reserved (ignored), [2:0] rb; imm_sel=1 uses zero-extended [5:0] as operand b.
- `instr_ready`  out  1  block can accept; high only in IDLE.
- `alu_opcode`  out  3  registered opcode to ALU.
- `alu_a`, `alu_b`  out  8  registered operands to ALU.
- `alu_out`  in  8  ALU result.
- `alu_zero`, `alu_carry`  in  1  ALU flags.
- `wb_valid`  out  1  one-cycle pulse, writeback occurring.
- `wb_addr`  out  3  destination register.
- `wb_data`  out  8  value written.
- `flag_z`, `flag_c`  out  1  architectural flags.
- `dbg_addr`  in  3  debug register select.
- `dbg_data`  out  8  combinational read of register `dbg_addr`.

## Operation
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not(a), 6 shl(a), 7 shr(a). Block never reinterprets them; it passes opcode through.
- FSM states IDLE, EXEC, WB. IDLE->EXEC on `instr_valid && instr_ready`; EXEC->WB unconditionally; WB->IDLE unconditionally.
- Accept edge: latch opcode, rd; load `alu_a` = R[ra], `alu_b` = imm_sel ? {2'b0, instr[5:0]} : R[rb].
- EXEC edge: capture `alu_out` into result register; `flag_z` <= `alu_zero` for every opcode; `flag_c` <= `alu_carry` only for opcode 0, otherwise held.
- WB edge: R[rd] <= result unless rd = 0.
- R0 hardwired to 0: reads return 0, writes discarded; `wb_valid` still pulses with computed `wb_data`, `wb_addr` = 0.
- Operands for unary ops (5,6,7) still driven from rb/imm; ALU ignores b.
- All arithmetic is 8-bit modulo; carry beyond bit 7 only via `flag_c`.
- `dbg_data` reflects register contents after the WB edge; R0 reads 0.

## Timing
- Reset (synchronous, dominates everything): state IDLE, all registers R0-R7 = 0, `alu_opcode`/`alu_a`/`alu_b` = 0, result = 0, `flag_z` = 0, `flag_c` = 0, `wb_valid` = 0, `wb_addr` = 0, `wb_data` = 0. `instr_ready` = 1 in the first cycle after reset deasserts; no accept occurs on an edge where `rst` is high.
- Latency: accept at edge T; ALU inputs stable during T..T+1; flags update at T+1; `wb_valid` high during T+1..T+2; register file updated at T+2.
- Throughput: one instruction per 3 cycles; `instr_ready` low in EXEC and WB.
- Back-to-back dependent instructions need no forwarding: next accept is at T+3 at the earliest, after R[rd] is written.
- `instr_data` only sampled on the accept edge; changes while `instr_ready` low are ignored. `instr_valid` may stay high across instructions.
- Reset mid-EXEC or mid-WB: instruction abandoned, no register write, `wb_valid` forced low.

## Structure
- Shared package: opcode constants (OP_ADD..OP_SHR), instruction field positions, FSM state enum, `DATA_W` default.
- One sub-module: `reg_file_8x8` — one synchronous write port, two combinational read ports plus a debug read port, R0 hardwired zero, synchronous reset to 0.
- Control FSM and ALU-side registers remain in `alu_issue_ctrl`.

## Test plan
- Reset then R1 <- 0+imm 0x3F (opcode 0, ra=0, imm_sel=1) -> `wb_valid` at T+1, `wb_data` = 0x3F, `dbg_data`(1) = 0x3F, `flag_z` = 0, `flag_c` = 0.
- R1=0xFF via chained immediates, add R2 <- R1+R1 -> `wb_data` = 0xFE, `flag_c` = 1; subsequent xor R3 <- R1^R1 -> 0x00, `flag_z` = 1, `flag_c` stays 1.
- Write to R0 (or rd=0, ra=R1) -> `wb_valid` pulses with `wb_data` = 0xFF, `dbg_data`(0) = 0.
- `instr_valid` held high with three instructions queued -> accepts exactly every 3 cycles, `instr_ready` low 2 of every 3 cycles, ALU ports show each opcode/operand pair for one EXEC cycle.
- Shl/shr/not on R1=0x81 -> 0x02, 0x40, 0x7E respectively; `flag_c` unchanged.
- Assert `rst` during EXEC of add to R4 -> no `wb_valid`, R4 = 0, all outputs at reset values next cycle.
